// File: rtl/rr_mux_4_1_if.sv
// Request/data bundle for the round-robin 4:1 mux: four requesters in, one registered word out.
interface rr_mux_4_1_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  // Requesters and downstream consumer
  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  ack, out_valid, out_data, out_sel
  );

  // Arbitrating mux
  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output ack, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_4_1.sv
// Round-robin arbiter over four requesters feeding a registered output word and
// its channel index, which drives the downstream mux select.
module rr_mux_4_1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_4_1_if.slave  bus
);

  logic [1:0]       ptr;
  logic [1:0]       win_c;
  logic [1:0]       idx_c;
  logic             found_c;
  logic             load_c;
  logic [WIDTH-1:0] data_c;

  // First requesting channel at or after ptr, wrapping mod 4
  always_comb begin
    win_c   = 2'd0;
    idx_c   = 2'd0;
    found_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx_c = ptr + 2'(k);
      if (!found_c && bus.req[idx_c]) begin
        win_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  // rst_n gates the load so nothing is acked while reset is held
  always_comb begin
    load_c  = rst_n && (!bus.out_valid || bus.out_ready) && found_c;
    bus.ack = 4'b0000;
    if (load_c) begin
      bus.ack[win_c] = 1'b1;
    end
  end

  always_comb begin
    data_c = bus.d0;
    case (win_c)
      2'd0:    data_c = bus.d0;
      2'd1:    data_c = bus.d1;
      2'd2:    data_c = bus.d2;
      default: data_c = bus.d3;
    endcase
  end

  // Output register and priority pointer; ptr moves only on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= 2'd0;
      ptr           <= 2'd0;
    end else if (load_c) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= data_c;
      bus.out_sel   <= win_c;
      ptr           <= win_c + 2'd1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Directed bench for rr_mux_4_1: reset, rotation, wrap, backpressure, drain, reset mid-stall.
module tb_rr_mux_4_1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rr_mux_4_1_if #(.WIDTH(4)) bus ();

  rr_mux_4_1 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] sel, input logic [3:0] data);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".sel"},   32'(bus.out_sel),   32'(sel));
    check({tag, ".data"},  32'(bus.out_data),  32'(data));
  endtask

  logic [1:0] rot_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [3:0] rot_dat [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
  logic [3:0] rot_ack [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [1:0] sp_sel  [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
  logic [3:0] sp_dat  [4] = '{4'h4, 4'h1, 4'h4, 4'h1};
  logic [3:0] sp_ack  [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;

    // Reset state with all requests pending
    #2;
    check("rst.ack", 32'(bus.ack), 32'(4'b0000));
    check_out("rst", 1'b0, 2'd0, 4'h0);
    step();
    step();
    check("rst.ack_held", 32'(bus.ack), 32'(4'b0000));
    rst_n = 1'b1;
    #1;
    check("rel.ack", 32'(bus.ack), 32'(4'b0001));

    // Full rotation with all four requesting
    for (int i = 0; i < 6; i++) begin
      step();
      check_out($sformatf("rot%0d", i), 1'b1, rot_sel[i], rot_dat[i]);
      check($sformatf("rot%0d.ack", i), 32'(bus.ack), 32'(rot_ack[i]));
    end

    // Sparse requests: ptr is 2, so grants go 3,0,3,0 and wrap 3->0
    bus.req = 4'b1001;
    #1;
    check("sp.ack0", 32'(bus.ack), 32'(4'b1000));
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("sp%0d", i), 1'b1, sp_sel[i], sp_dat[i]);
      check($sformatf("sp%0d.ack", i), 32'(bus.ack), 32'(sp_ack[i]));
      check($sformatf("sp%0d.ack12", i), 32'(bus.ack & 4'b0110), 32'(4'b0000));
    end

    // Backpressure: load channel 2 then stall with everyone requesting
    bus.d2  = 4'hA;
    bus.req = 4'b0100;
    step();
    check_out("bp.load", 1'b1, 2'd2, 4'hA);
    bus.out_ready = 1'b0;
    bus.req       = 4'b1111;
    #1;
    check("bp.ack", 32'(bus.ack), 32'(4'b0000));
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp%0d", i), 1'b1, 2'd2, 4'hA);
      check($sformatf("bp%0d.ack", i), 32'(bus.ack), 32'(4'b0000));
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.resume_ack", 32'(bus.ack), 32'(4'b1000));
    step();
    check_out("bp.resume", 1'b1, 2'd3, 4'h4);

    // Drain and idle: ptr is 0 and must not rotate while idle
    bus.req = 4'b0000;
    #1;
    check("dr.ack", 32'(bus.ack), 32'(4'b0000));
    step();
    check_out("dr0", 1'b0, 2'd3, 4'h4);
    step();
    check_out("dr1", 1'b0, 2'd3, 4'h4);
    bus.req = 4'b1111;
    #1;
    check("dr.ptr_kept", 32'(bus.ack), 32'(4'b0001));
    bus.req = 4'b0001;
    #1;
    check("dr.first_ack", 32'(bus.ack), 32'(4'b0001));
    step();
    check_out("dr.grant", 1'b1, 2'd0, 4'h1);

    // Reset asserted mid-stall: ptr is 1 before reset
    bus.out_ready = 1'b0;
    bus.req       = 4'b1111;
    step();
    check_out("rs.stall", 1'b1, 2'd0, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs.valid", 32'(bus.out_valid), 32'(1'b0));
    check("rs.ack", 32'(bus.ack), 32'(4'b0000));
    bus.out_ready = 1'b1;
    step();
    check("rs.ack_held", 32'(bus.ack), 32'(4'b0000));
    rst_n = 1'b1;
    #1;
    check("rs.ptr0", 32'(bus.ack), 32'(4'b0001));
    step();
    check_out("rs.grant", 1'b1, 2'd0, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
